// File: rtl/led_serial_tx_pkg.sv
// Shared types and default LED timing for the LED pixel pipeline.
// Defaults match the receive-side thresholds so both ends agree at 50 MHz.
package pipeline_types;

   typedef logic [23:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW,
      LATCH
   } tx_state_e;

   typedef struct packed {
      pixel_t pixel;
      logic   last;
   } tx_input_t;

   localparam int DEF_T0H_CYCLES   = 20;
   localparam int DEF_T1H_CYCLES   = 40;
   localparam int DEF_BIT_CYCLES   = 63;
   localparam int DEF_RESET_CYCLES = 2500;

endpackage

// File: rtl/led_serial_tx_bit_timer.sv
// Shared cycle counter for bit phases, the latch gap and the underrun idle count.
// Clear has priority over increment; compare outputs are pure decodes of the count.
module led_tx_bit_timer #(
   parameter int T0H_CYCLES   = 20,
   parameter int T1H_CYCLES   = 40,
   parameter int BIT_CYCLES   = 63,
   parameter int RESET_CYCLES = 2500,
   parameter int CNT_W        = $clog2(RESET_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic t0h_hit,
   output logic t1h_hit,
   output logic bit_end,
   output logic reset_end
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign t0h_hit   = (count == CNT_W'(T0H_CYCLES - 1));
   assign t1h_hit   = (count == CNT_W'(T1H_CYCLES - 1));
   assign bit_end   = (count == CNT_W'(BIT_CYCLES - 1));
   assign reset_end = (count == CNT_W'(RESET_CYCLES - 1));

endmodule

// File: rtl/led_serial_tx.sv
// Serialises 24-bit GRB pixels onto a single-wire NRZ LED line, MSB first,
// with a low latch gap after the last pixel of a frame.
module led_serial_tx
   import pipeline_types::*;
#(
   parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
   parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
   parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int CNT_W        = $clog2(RESET_CYCLES + 1)
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [23:0] i_pixel,
   input  logic        i_last,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_serial,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_underrun
);

   // Handshake: a pixel transfers on any rising edge where i_valid && o_ready;
   // i_valid may be held across cycles and o_ready never depends on i_valid.

   if (T0H_CYCLES <= 0 || T1H_CYCLES <= T0H_CYCLES || BIT_CYCLES <= T1H_CYCLES
       || RESET_CYCLES < 1) begin : g_bad_timing
      $error("led_serial_tx: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and RESET_CYCLES >= 1");
   end
   if (BIT_CYCLES > (1 << CNT_W)) begin : g_bad_width
      $error("led_serial_tx: CNT_W too narrow for BIT_CYCLES");
   end

   tx_state_e state, state_nx;
   tx_input_t cur;
   tx_input_t in_word;
   logic [4:0] bit_idx;
   logic       frame_open;

   logic cnt_clear, cnt_inc;
   logic t0h_hit, t1h_hit, bit_end, reset_end;
   logic accept, high_done, last_bit_end, idle_term, latch_end;

   led_tx_bit_timer #(
      .T0H_CYCLES  (T0H_CYCLES),
      .T1H_CYCLES  (T1H_CYCLES),
      .BIT_CYCLES  (BIT_CYCLES),
      .RESET_CYCLES(RESET_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk      (i_clk),
      .reset    (i_reset),
      .clear    (cnt_clear),
      .inc      (cnt_inc),
      .t0h_hit  (t0h_hit),
      .t1h_hit  (t1h_hit),
      .bit_end  (bit_end),
      .reset_end(reset_end)
   );

   assign in_word      = '{pixel: i_pixel, last: i_last};
   assign high_done    = cur.pixel[23] ? t1h_hit : t0h_hit;
   assign last_bit_end = (state == LOW) && bit_end && (bit_idx == 5'd0);
   assign latch_end    = (state == LATCH) && reset_end;
   // The idle count is the same timer, running only while a frame is left open.
   assign idle_term    = (state == IDLE) && frame_open && reset_end;

   assign o_ready = !i_reset && ((state == IDLE) || (last_bit_end && !cur.last));
   assign accept  = i_valid && o_ready;
   assign o_busy  = (state != IDLE);

   always_comb begin
      state_nx  = state;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b1;
      case (state)
         IDLE: begin
            cnt_inc = frame_open;
            if (accept) begin
               state_nx  = HIGH;
               cnt_clear = 1'b1;
            end
         end
         HIGH: begin
            // Counter keeps running into LOW so the bit period stays exact.
            if (high_done) state_nx = LOW;
         end
         LOW: begin
            if (bit_end) begin
               cnt_clear = 1'b1;
               if (bit_idx != 5'd0) state_nx = HIGH;
               else if (cur.last)   state_nx = LATCH;
               else if (accept)     state_nx = HIGH;
               else                 state_nx = IDLE;
            end
         end
         LATCH: begin
            if (reset_end) begin
               state_nx  = IDLE;
               cnt_clear = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= IDLE;
         cur          <= '0;
         bit_idx      <= 5'd23;
         frame_open   <= 1'b0;
         o_serial     <= 1'b0;
         o_frame_done <= 1'b0;
         o_underrun   <= 1'b0;
      end else begin
         state        <= state_nx;
         o_serial     <= (state_nx == HIGH);
         o_frame_done <= latch_end;
         o_underrun   <= idle_term;
         if (accept) begin
            cur        <= in_word;
            bit_idx    <= 5'd23;
            frame_open <= 1'b1;
         end else begin
            if ((state == LOW) && bit_end && (bit_idx != 5'd0)) begin
               cur.pixel <= {cur.pixel[22:0], 1'b0};
               bit_idx   <= bit_idx - 5'd1;
            end
            if (idle_term || latch_end) frame_open <= 1'b0;
         end
      end
   end

endmodule
